// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: request/result bundle between the control FSM and multicycle_alu
interface multicycle_alu_if #(parameter int WIDTH = 32);
  logic start, busy, done, zero, overflow;
  logic [WIDTH-1:0] srcA, srcB, aluresult;
  logic [3:0] alucontrol;
  modport master (output start, srcA, srcB, alucontrol, input busy, done, aluresult, zero, overflow);
  modport slave (input start, srcA, srcB, alucontrol, output busy, done, aluresult, zero, overflow);
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with start/busy/done handshake and iterative restoring divider
module multicycle_alu #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  multicycle_alu_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, DIVIDE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, sum, diff, y, quo, dvs, res, q_next;
  logic [WIDTH:0] rem, shifted, trial, r_next;
  logic [CW-1:0] cnt;
  logic ovf, done_r, is_rem, y_ovf, div_op, b_zero, last;
  assign a = bus.srcA;
  assign b = bus.srcB;
  assign sum = a + b;
  assign diff = a - b;
  assign div_op = bus.alucontrol inside {4'b1010, 4'b1011};
  assign b_zero = b == '0;
  assign last = cnt == CW'(WIDTH - 1);
  assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial = shifted - {1'b0, dvs};
  assign r_next = trial[WIDTH] ? shifted : trial;
  assign q_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign bus.busy = state == DIVIDE;
  assign bus.done = done_r;
  assign bus.aluresult = res;
  assign bus.zero = res == '0;
  assign bus.overflow = ovf;
  // DIV/REM arms here only serve the divide-by-zero single-cycle path
  always_comb begin
    y = '0;
    y_ovf = 1'b0;
    case (bus.alucontrol)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: begin
        y = sum;
        y_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        y = diff;
        y_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: y = WIDTH'(a < b);
      4'b1100: y = ~(a | b);
      4'b1010: y = '1;
      4'b1011: y = a;
      default: y = '0;
    endcase
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.start && div_op && !b_zero) state_n = DIVIDE;
    else if (state == DIVIDE && last) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
      ovf <= 1'b0;
      done_r <= 1'b0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      cnt <= '0;
      is_rem <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start && div_op && !b_zero) begin
          quo <= a;
          rem <= '0;
          dvs <= b;
          cnt <= '0;
          is_rem <= bus.alucontrol[0];
        end else if (bus.start) begin
          res <= y;
          ovf <= y_ovf;
          done_r <= 1'b1;
        end
      end else begin
        quo <= q_next;
        rem <= r_next;
        cnt <= cnt + 1'b1;
        if (last) begin
          res <= is_rem ? r_next[WIDTH-1:0] : q_next;
          ovf <= 1'b0;
          done_r <= 1'b1;
          cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: table-driven and scoreboarded checks of multicycle_alu at WIDTH=32
module tb_multicycle_alu;
  localparam int W = 32;
  typedef struct {logic [3:0] op; logic [W-1:0] a, b, y; logic ov;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  multicycle_alu_if #(.WIDTH(W)) bus();
  multicycle_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [W:0] exp_q[$];
  vec_t vt[15];
  int checks = 0, errors = 0, done_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic tick();
    logic [W:0] e;
    @(posedge clk);
    #1;
    if (bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=%h want=no_done", bus.aluresult);
      end else begin
        e = exp_q.pop_front();
        check("result", {bus.aluresult, bus.overflow, bus.zero, bus.busy}, {e, e[W:1] == '0, 1'b0});
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [W-1:0] y, input logic ov);
    bus.start = 1'b1;
    bus.alucontrol = op;
    bus.srcA = a;
    bus.srcB = b;
    if (push) exp_q.push_back({y, ov});
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int n, dc;
    bus.start = 1'b0;
    bus.srcA = '0;
    bus.srcB = '0;
    bus.alucontrol = '0;
    vt[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    vt[1]  = '{4'h6, 32'd5,        32'd5,        32'h00000000, 1'b0};
    vt[2]  = '{4'h7, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b0};
    vt[3]  = '{4'hC, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0};
    vt[4]  = '{4'h0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vt[5]  = '{4'h1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0};
    vt[6]  = '{4'h6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    vt[7]  = '{4'h2, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
    vt[8]  = '{4'h2, 32'd3,        32'd4,        32'd7,        1'b0};
    vt[9]  = '{4'h7, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0};
    vt[10] = '{4'h3, 32'd5,        32'd6,        32'h00000000, 1'b0};
    vt[11] = '{4'h6, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vt[12] = '{4'hF, 32'h12345678, 32'd9,        32'h00000000, 1'b0};
    vt[13] = '{4'hA, 32'd123,      32'd0,        32'hFFFFFFFF, 1'b0};
    vt[14] = '{4'hB, 32'd123,      32'd0,        32'd123,      1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.start = i[0];
      bus.srcA = 32'hDEAD0000 + i;
      bus.srcB = 32'd1;
      bus.alucontrol = 4'h2;
      tick();
      check("reset_state", {bus.aluresult, bus.zero, bus.busy, bus.done}, {32'd0, 1'b1, 1'b0, 1'b0});
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, 1'b1, vt[i].y, vt[i].ov);
      check("b2b_done_no_busy", {bus.done, bus.busy}, 2'b10);
    end
    tick();
    check("done_falls", bus.done, 1'b0);
    issue(4'hA, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    check("div_busy_cycles", n, 32);
    check("div_done", bus.done, 1'b1);
    issue(4'hB, 32'd100, 32'd7, 1'b1, 32'd2, 1'b0);
    n = 1;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check("rem_latency", n, 33);
    tick();
    // stray starts mid-divide, including a would-be single-cycle divide by zero
    dc = done_cnt;
    issue(4'hA, 32'd1000, 32'd10, 1'b1, 32'd100, 1'b0);
    for (int k = 1; k < 32; k++) begin
      if (k == 7) issue(4'h2, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0);
      else if (k == 14) issue(4'hA, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0);
      else if (k == 21) issue(4'hB, 32'd77, 32'd5, 1'b0, 32'd0, 1'b0);
      else if (k == 28) issue(4'hC, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
      else tick();
    end
    repeat (3) tick();
    check("busy_single_done", done_cnt - dc, 1);
    check("busy_queue_empty", exp_q.size(), 0);
    issue(4'hA, 32'hFFFFFFFF, 32'd3, 1'b0, 32'd0, 1'b0);
    repeat (10) tick();
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort_reset", {bus.aluresult, bus.zero, bus.overflow, bus.busy, bus.done},
          {32'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("abort_no_done", done_cnt - dc, 0);
    issue(4'hA, 32'hFFFFFFFF, 32'd3, 1'b1, 32'h55555555, 1'b0);
    n = 1;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check("div_after_abort", n, 33);
    tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
